// File: rtl/seg_scan_ctrl.sv
// Scan controller for a multiplexed common-anode 7-segment display sharing one hex decoder.
// Optional build macro LEADING_ZERO_SUPPRESS_EN blanks leading zero digits at frame capture.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD_CYC   = 1000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  output logic [3:0]              dec_hex,
  input  logic [6:0]              dec_seg,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0]      GUARD_END = CNT_W'(GUARD_CYC);
  localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_ONE    = NUM_DIGITS'(1);
  localparam logic [6:0]            SEG_DARK  = 7'h7F;

`ifdef LEADING_ZERO_SUPPRESS_EN
  // Walks down from the leftmost digit, blanking zeros until the first nonzero; digit 0 always survives.
  function automatic logic [NUM_DIGITS-1:0] lead_zero_blank(input logic [4*NUM_DIGITS-1:0] dig);
    logic [NUM_DIGITS-1:0] blk;
    logic                  zero_run;
    blk      = '0;
    zero_run = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      if (zero_run && (dig[4*k +: 4] == 4'h0)) begin
        blk[k] = 1'b1;
      end else begin
        zero_run = 1'b0;
      end
    end
    return blk;
  endfunction
`endif

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] snap_dig_q, snap_dig_d;
  logic [NUM_DIGITS-1:0]   snap_dp_q, snap_dp_d;
  logic [NUM_DIGITS-1:0]   snap_blank_q, snap_blank_d;
  logic                    need_cap_q, need_cap_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic                    slot_end_s;
  logic                    capture_s;
  logic                    lit_s;
  logic [NUM_DIGITS-1:0]   cap_blank_s;

`ifdef LEADING_ZERO_SUPPRESS_EN
  assign cap_blank_s = blank_mask | lead_zero_blank(digits);
`else
  assign cap_blank_s = blank_mask;
`endif

  assign slot_end_s = (cnt_q == CNT_LAST);
  assign dec_hex    = snap_dig_q[{idx_q, 2'b00} +: 4];

  // Slot counter, digit index and once-per-frame snapshot; all state freezes while en is low.
  always_comb begin
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    need_cap_d = need_cap_q;
    capture_s  = 1'b0;
    if (en) begin
      if (slot_end_s) begin
        cnt_d = '0;
        if (idx_q == IDX_LAST) begin
          idx_d     = '0;
          capture_s = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      if (need_cap_q) begin
        capture_s  = 1'b1;
        need_cap_d = 1'b0;
      end else begin
        need_cap_d = need_cap_q;
      end
    end else begin
      cnt_d = cnt_q;
      idx_d = idx_q;
    end
  end

  // Snapshot next-state: a whole frame is taken from one capture so digits never tear.
  always_comb begin
    snap_dig_d   = snap_dig_q;
    snap_dp_d    = snap_dp_q;
    snap_blank_d = snap_blank_q;
    if (capture_s) begin
      snap_dig_d   = digits;
      snap_dp_d    = dp_mask;
      snap_blank_d = cap_blank_s;
    end else begin
      snap_dig_d   = snap_dig_q;
      snap_dp_d    = snap_dp_q;
      snap_blank_d = snap_blank_q;
    end
  end

  // Pin next-state: dark during guard, blanked digits or disable; otherwise a single anode low.
  always_comb begin
    lit_s = en && (cnt_q >= GUARD_END) && !snap_blank_q[idx_q];
    an_d  = '1;
    seg_d = SEG_DARK;
    dp_d  = 1'b1;
    if (lit_s) begin
      an_d  = ~(AN_ONE << idx_q);
      seg_d = dec_seg;
      dp_d  = ~snap_dp_q[idx_q];
    end else begin
      an_d  = '1;
      seg_d = SEG_DARK;
      dp_d  = 1'b1;
    end
  end

  // Scan state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      snap_dig_q   <= '0;
      snap_dp_q    <= '0;
      snap_blank_q <= '0;
      need_cap_q   <= 1'b1;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      snap_dig_q   <= snap_dig_d;
      snap_dp_q    <= snap_dp_d;
      snap_blank_q <= snap_blank_d;
      need_cap_q   <= need_cap_d;
    end
  end

  // Output pin registers; anodes and segments always update on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      an_q  <= '1;
      seg_q <= SEG_DARK;
      dp_q  <= 1'b1;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: stimulus queues per-cycle pin expectations, a monitor checks them.
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [15:0] digits;
  logic [3:0]  dp_mask;
  logic [3:0]  blank_mask;
  logic [3:0]  dec_hex;
  logic [6:0]  dec_seg;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;

  typedef struct {
    int         tag;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t exp_q[$];
  int   cyc_cnt = 0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Active-high abcdefg patterns; the board decoder is the complement.
  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: return 7'h7E;
      4'h1: return 7'h30;
      4'h2: return 7'h6D;
      4'h3: return 7'h79;
      4'h4: return 7'h33;
      4'h5: return 7'h5B;
      4'h6: return 7'h5F;
      4'h7: return 7'h70;
      4'h8: return 7'h7F;
      4'h9: return 7'h7B;
      4'hA: return 7'h77;
      4'hB: return 7'h1F;
      4'hC: return 7'h4E;
      4'hD: return 7'h3D;
      4'hE: return 7'h4F;
      4'hF: return 7'h47;
      default: return 7'h00;
    endcase
  endfunction

  assign dec_seg = ~hex7(dec_hex);

  seg_scan_ctrl #(.NUM_DIGITS(4), .REFRESH_DIV(8), .GUARD_CYC(2)) dut (
    .clk(clk), .reset(reset), .en(en), .digits(digits), .dp_mask(dp_mask),
    .blank_mask(blank_mask), .dec_hex(dec_hex), .dec_seg(dec_seg),
    .seg(seg), .dp(dp), .an(an)
  );

  // Expectation for what the pins show one edge after the current cycle, then advance a cycle.
  task automatic push_exp(input logic [3:0] a, input logic [6:0] s, input logic d);
    exp_t e;
    e.tag = cyc_cnt + 1;
    e.an  = a;
    e.seg = s;
    e.dp  = d;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic push_dark();
    push_exp(4'b1111, 7'h7F, 1'b1);
  endtask

  // Cycles c_from..c_to of digit d's slot: 2 guard cycles dark, rest lit unless blanked.
  task automatic slot(input int d, input logic [3:0] nib, input logic dp_on, input logic blk,
                      input int c_from, input int c_to);
    logic [3:0] a;
    for (int c = c_from; c <= c_to; c++) begin
      a    = 4'b1111;
      a[d] = 1'b0;
      if (c < 2 || blk) push_dark();
      else              push_exp(a, ~hex7(nib), ~dp_on);
    end
  endtask

  task automatic frame(input logic [15:0] v, input logic [3:0] dpm, input logic [3:0] blm);
    for (int d = 0; d < 4; d++) slot(d, v[4*d +: 4], dpm[d], blm[d], 0, 7);
  endtask

  // Monitor: pops and compares the expectation due in the current cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].tag < cyc_cnt) begin
        e = exp_q.pop_front();
        vectors++;
        miscompares++;
        $display("FAIL stale_expect tag=%0d got cycle=%0d want cycle=%0d", e.tag, cyc_cnt, e.tag);
      end
      if (exp_q.size() > 0 && exp_q[0].tag == cyc_cnt) begin
        e = exp_q.pop_front();
        vectors++;
        if (an !== e.an || seg !== e.seg || dp !== e.dp) begin
          miscompares++;
          $display("FAIL pins cycle=%0d got an=%b seg=%h dp=%b want an=%b seg=%h dp=%b",
                   cyc_cnt, an, seg, dp, e.an, e.seg, e.dp);
        end
        vectors++;
        if ($countones(~an) > 1) begin
          miscompares++;
          $display("FAIL anode_onehot cycle=%0d got an=%b want at most one low", cyc_cnt, an);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got time=%0t want finish earlier", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    en         = 1'b1;
    digits     = 16'h1234;
    dp_mask    = 4'b0000;
    blank_mask = 4'b0000;
    @(posedge clk);
    #1;
    repeat (3) push_dark();
    reset = 1'b0;

    // Plain scan, two frames.
    frame(16'h1234, 4'b0000, 4'b0000);
    frame(16'h1234, 4'b0000, 4'b0000);

    // Input change mid-frame must not tear the current frame.
    slot(0, 4'h4, 1'b0, 1'b0, 0, 7);
    slot(1, 4'h3, 1'b0, 1'b0, 0, 7);
    digits = 16'h5678;
    slot(2, 4'h2, 1'b0, 1'b0, 0, 7);
    slot(3, 4'h1, 1'b0, 1'b0, 0, 7);

    // New data next frame; DP/blank masks applied mid-frame take effect one frame later.
    slot(0, 4'h8, 1'b0, 1'b0, 0, 7);
    dp_mask    = 4'b0100;
    blank_mask = 4'b0001;
    slot(1, 4'h7, 1'b0, 1'b0, 0, 7);
    slot(2, 4'h6, 1'b0, 1'b0, 0, 7);
    slot(3, 4'h5, 1'b0, 1'b0, 0, 7);

    slot(0, 4'h8, 1'b0, 1'b1, 0, 7);
    dp_mask    = 4'b0000;
    blank_mask = 4'b0000;
    slot(1, 4'h7, 1'b0, 1'b0, 0, 7);
    slot(2, 4'h6, 1'b1, 1'b0, 0, 7);
    slot(3, 4'h5, 1'b0, 1'b0, 0, 7);

    // Enable hold at the last cycle of digit 1's slot.
    slot(0, 4'h8, 1'b0, 1'b0, 0, 7);
    slot(1, 4'h7, 1'b0, 1'b0, 0, 6);
    en = 1'b0;
    repeat (5) push_dark();
    en = 1'b1;
    slot(1, 4'h7, 1'b0, 1'b0, 7, 7);
    slot(2, 4'h6, 1'b0, 1'b0, 0, 7);
    digits = 16'h0070;
    slot(3, 4'h5, 1'b0, 1'b0, 0, 7);

`ifdef LEADING_ZERO_SUPPRESS_EN
    frame(16'h0070, 4'b0000, 4'b1100);
`else
    frame(16'h0070, 4'b0000, 4'b0000);
`endif

    // Reset in the middle of digit 1's slot restarts from digit 0.
    slot(0, 4'h0, 1'b0, 1'b0, 0, 7);
    slot(1, 4'h7, 1'b0, 1'b0, 0, 3);
    reset = 1'b1;
    push_dark();
    reset = 1'b0;
`ifdef LEADING_ZERO_SUPPRESS_EN
    frame(16'h0070, 4'b0000, 4'b1100);
`else
    frame(16'h0070, 4'b0000, 4'b0000);
`endif

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain got pending=%0d want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
